// File: rtl/clock_enable_chain.sv
`default_nettype none
// ============================================================================
//  Module      : clock_enable_chain
//  Description : Parametrised clock-enable divider. Turns a base enable into
//                per-stage rise/fall enables, a toggle clock pair and a
//                registered half-rate tap. It also provides start-up delay,
//                HOLD freeze and a RESYNC phase-realign handshake.
//                Optional build macro: CLOCKS_TRIM_EN. When it is defined,
//                the TRIM_PHASE input supplies the realign phase.
//  Revision    : 1.0 - initial release
// ============================================================================
module clock_enable_chain #(
    parameter int                  DIV_BITS    = 3,
    parameter logic [DIV_BITS-1:0] RESET_PHASE = DIV_BITS'(3'b100),
    parameter int                  START_DELAY = 4,
    parameter int                  HB_TAP      = 2
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                CLK_EN_IN,
    input  logic                HOLD,
    input  logic                RESYNC,
`ifdef CLOCKS_TRIM_EN
    input  logic [DIV_BITS-1:0] TRIM_PHASE,
`endif
    output logic                RESYNC_ACK,
    output logic                RUNNING,
    output logic [DIV_BITS-1:0] CLK_DIV,
    output logic [DIV_BITS-1:0] EN_RISE,
    output logic [DIV_BITS-1:0] EN_FALL,
    output logic                TOGGLE,
    output logic                TOGGLE_B,
    output logic                TAP_HB
);

    typedef enum logic [1:0] {
        ST_DELAY = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALIGN = 2'd2
    } state_t;

    localparam logic [8:0] c_dly_last = 9'(START_DELAY);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [7:0]          r_dly_cnt;
    logic [DIV_BITS-1:0] r_div;
    logic [DIV_BITS-1:0] w_phase;
    logic [DIV_BITS-1:0] w_carry;
    logic                r_toggle;
    logic                r_tap;
    logic                r_ack;
    logic                w_base;
    logic                w_tick;
    logic                w_dly_done;
    logic                w_align_load;

    // A frozen base enable stalls every counter and the FSM together.
    assign w_base       = CLK_EN_IN & ~HOLD;
    assign w_tick       = w_base & (r_state == ST_RUN) & ~RESET;
    assign w_align_load = w_base & (r_state == ST_ALIGN);

`ifdef CLOCKS_TRIM_EN
    assign w_phase = TRIM_PHASE;
`else
    assign w_phase = RESET_PHASE;
`endif

    // With no start-up delay, the block leaves DELAY on the first unfrozen edge.
    generate
        if (START_DELAY == 0) begin : g_no_delay
            assign w_dly_done = 1'b1;
        end else begin : g_delay
            assign w_dly_done = w_base & (({1'b0, r_dly_cnt} + 9'd1) == c_dly_last);
        end
    endgenerate

    // A stage toggles when all lower bits are set. That prefix AND is a carry chain.
    generate
        for (genvar k = 0; k < DIV_BITS; k++) begin : g_stage
            if (k == 0) begin : g_first
                assign w_carry[k] = 1'b1;
            end else begin : g_next
                assign w_carry[k] = w_carry[k-1] & r_div[k-1];
            end
            assign EN_RISE[k] = w_tick & w_carry[k] & ~r_div[k];
            assign EN_FALL[k] = w_tick & w_carry[k] &  r_div[k];
        end
    endgenerate

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= ST_DELAY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. HOLD pins the FSM in whatever state it is in.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_DELAY: if (!HOLD && w_dly_done) w_state_nxt = ST_RUN;
            ST_RUN:   if (!HOLD && RESYNC)     w_state_nxt = ST_ALIGN;
            ST_ALIGN: if (w_base)              w_state_nxt = ST_RUN;
            default:                           w_state_nxt = ST_DELAY;
        endcase
    end

    // Divider, toggle, tap, delay counter and realign acknowledge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_dly_cnt <= 8'd0;
            r_div     <= RESET_PHASE;
            r_toggle  <= 1'b0;
            r_tap     <= ~RESET_PHASE[HB_TAP];
            r_ack     <= 1'b0;
        end else begin
            r_ack <= w_align_load;
            if ((r_state == ST_DELAY) && w_base && !w_dly_done) begin
                r_dly_cnt <= r_dly_cnt + 8'd1;
            end
            if (w_tick) begin
                r_div    <= r_div + DIV_BITS'(1);
                r_toggle <= ~r_toggle;
                // The tap is sampled on the bit-0 rising edge, before the increment.
                if (!r_div[0]) begin
                    r_tap <= ~r_div[HB_TAP];
                end
            end
            if (w_align_load) begin
                r_div    <= w_phase;
                r_toggle <= 1'b0;
            end
        end
    end

    assign RUNNING    = (r_state == ST_RUN) & ~RESET;
    assign CLK_DIV    = r_div;
    assign TOGGLE     = r_toggle;
    assign TOGGLE_B   = ~r_toggle;
    assign TAP_HB     = r_tap;
    assign RESYNC_ACK = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_clock_enable_chain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_clock_enable_chain
//  Description : Scoreboard bench for clock_enable_chain with default
//                parameters. It drives CLK_EN_IN every other CLK, HOLD,
//                RESYNC and RESET.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_enable_chain;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       CLK_EN_IN;
    logic       HOLD;
    logic       RESYNC;
    logic       RESYNC_ACK;
    logic       RUNNING;
    logic [2:0] CLK_DIV;
    logic [2:0] EN_RISE;
    logic [2:0] EN_FALL;
    logic       TOGGLE;
    logic       TOGGLE_B;
    logic       TAP_HB;
`ifdef CLOCKS_TRIM_EN
    logic [2:0] TRIM_PHASE = 3'd1;
`endif

    clock_enable_chain u_dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .CLK_EN_IN  (CLK_EN_IN),
        .HOLD       (HOLD),
        .RESYNC     (RESYNC),
`ifdef CLOCKS_TRIM_EN
        .TRIM_PHASE (TRIM_PHASE),
`endif
        .RESYNC_ACK (RESYNC_ACK),
        .RUNNING    (RUNNING),
        .CLK_DIV    (CLK_DIV),
        .EN_RISE    (EN_RISE),
        .EN_FALL    (EN_FALL),
        .TOGGLE     (TOGGLE),
        .TOGGLE_B   (TOGGLE_B),
        .TAP_HB     (TAP_HB)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       running;
        logic [2:0] div;
        logic [2:0] rise;
        logic [2:0] fall;
        logic       tog;
        logic       tog_b;
        logic       tap;
        logic       ack;
    } obs_t;

    obs_t q_exp[$];
    obs_t q_act[$];
    obs_t last_act;
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model: 0 = DELAY, 1 = RUN, 2 = ALIGN.
    int         m_st;
    int         m_cnt;
    logic [2:0] m_div;
    logic       m_tog;
    logic       m_tap;
    logic       m_ack;
`ifdef CLOCKS_TRIM_EN
    logic [2:0] m_phase = 3'd1;
`else
    logic [2:0] m_phase = 3'd4;
`endif

    function automatic obs_t model_out(input logic en, input logic hold, input logic rst);
        obs_t       o;
        logic       tick;
        logic [2:0] nxt;
        logic [2:0] chg;
        tick      = en & ~hold & (m_st == 1) & ~rst;
        nxt       = m_div + 3'd1;
        chg       = m_div ^ nxt;
        o.running = (m_st == 1) & ~rst;
        o.div     = m_div;
        o.rise    = tick ? (chg & nxt)   : 3'b000;
        o.fall    = tick ? (chg & m_div) : 3'b000;
        o.tog     = m_tog;
        o.tog_b   = ~m_tog;
        o.tap     = m_tap;
        o.ack     = m_ack;
        return o;
    endfunction

    task automatic model_step(input logic en, input logic hold, input logic rs, input logic rst);
        logic base;
        base = en & ~hold;
        if (rst) begin
            m_st = 0; m_cnt = 0; m_div = 3'd4; m_tog = 1'b0; m_tap = 1'b0; m_ack = 1'b0;
        end else begin
            m_ack = 1'b0;
            case (m_st)
                0: if (base) begin
                       if (m_cnt + 1 == 4) m_st = 1;
                       else m_cnt = m_cnt + 1;
                   end
                1: begin
                       if (base) begin
                           if (!m_div[0]) m_tap = ~m_div[2];
                           m_div = m_div + 3'd1;
                           m_tog = ~m_tog;
                       end
                       if (rs && !hold) m_st = 2;
                   end
                default: if (base) begin
                       m_div = m_phase; m_tog = 1'b0; m_ack = 1'b1; m_st = 1;
                   end
            endcase
        end
    endtask

    // Drive one CLK cycle. Push the expected outputs, then capture the DUT outputs.
    task automatic drive(input logic en, input logic hold, input logic rs, input logic rst);
        CLK_EN_IN = en; HOLD = hold; RESYNC = rs; RESET = rst;
        q_exp.push_back(model_out(en, hold, rst));
        @(negedge CLK);
        last_act.running = RUNNING;
        last_act.div     = CLK_DIV;
        last_act.rise    = EN_RISE;
        last_act.fall    = EN_FALL;
        last_act.tog     = TOGGLE;
        last_act.tog_b   = TOGGLE_B;
        last_act.tap     = TAP_HB;
        last_act.ack     = RESYNC_ACK;
        q_act.push_back(last_act);
        @(posedge CLK);
        model_step(en, hold, rs, rst);
        #1;
    endtask

    task automatic test_reset;
        obs_t e, a;
        for (int i = 0; i < 4; i++) drive(i[0], 1'b0, 1'b1, 1'b1);
        n_vec++;
        if (last_act.div !== 3'd4 || last_act.running !== 1'b0 || last_act.tap !== 1'b0 ||
            last_act.rise !== 3'd0 || last_act.ack !== 1'b0) begin
            n_err++;
            $display("FAIL reset_values: got %h required div=4 run=0 tap=0 en=0 ack=0", last_act);
        end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); a = q_act.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL reset_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_startup;
        obs_t       e, a;
        logic [2:0] seq [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
        for (int i = 0; i < 8; i++) drive(~i[0], 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (last_act.running !== 1'b1 || last_act.div !== seq[i] || last_act.tog !== i[0]) begin
                n_err++;
                $display("FAIL startup_seq[%0d]: got run=%b div=%0d tog=%b required run=1 div=%0d tog=%b",
                         i, last_act.running, last_act.div, last_act.tog, seq[i], i[0]);
            end
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 16; i++) drive(~i[0], 1'b0, 1'b0, 1'b0);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); a = q_act.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL startup_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_hold;
        obs_t e, a;
        logic tog0, tap0;
        for (int i = 0; i < 10 && m_div != 3'd5; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        tog0 = m_tog; tap0 = m_tap;
        for (int i = 0; i < 12; i++) begin
            drive(~i[0], 1'b1, 1'b0, 1'b0);
            n_vec++;
            if (last_act.div !== 3'd5 || last_act.rise !== 3'd0 || last_act.fall !== 3'd0 ||
                last_act.tog !== tog0 || last_act.tap !== tap0) begin
                n_err++;
                $display("FAIL hold_freeze: got %h required div=5 en=0 tog=%b tap=%b", last_act, tog0, tap0);
            end
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (last_act.div !== 3'd6) begin
            n_err++; $display("FAIL hold_resume: got div=%0d required 6", last_act.div);
        end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); a = q_act.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL hold_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_resync;
        obs_t e, a;
        for (int i = 0; i < 10 && m_div != 3'd2; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (last_act.running !== 1'b0) begin
            n_err++; $display("FAIL align_state: got running=%b required 0", last_act.running);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (last_act.ack !== 1'b1 || last_act.div !== m_phase || last_act.tog !== 1'b0) begin
            n_err++;
            $display("FAIL resync_load: got ack=%b div=%0d tog=%b required ack=1 div=%0d tog=0",
                     last_act.ack, last_act.div, last_act.tog, m_phase);
        end
        for (int i = 0; i < 4; i++) begin
            drive(~i[0], 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (last_act.ack !== 1'b0) begin
                n_err++; $display("FAIL resync_single_ack: got ack=%b required 0", last_act.ack);
            end
        end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) drive(~i[0], 1'b0, 1'b0, 1'b0);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); a = q_act.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL resync_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_reset_in_align;
        obs_t e, a;
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if (last_act.ack !== 1'b0 || last_act.div !== 3'd4 || last_act.running !== 1'b0 ||
                last_act.tog !== 1'b0) begin
                n_err++;
                $display("FAIL reset_in_align: got %h required ack=0 div=4 run=0 tog=0", last_act);
            end
        end
        for (int i = 0; i < 12; i++) drive(~i[0], 1'b0, 1'b0, 1'b0);
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); a = q_act.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL reset_align_sb: got %h required %h", a, e); end
        end
    endtask

    task automatic test_random;
        obs_t e, a;
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 9) == 0), ($urandom_range(0, 79) == 0));
        end
        while (q_exp.size() > 0) begin
            e = q_exp.pop_front(); a = q_act.pop_front(); n_vec++;
            if (a !== e) begin n_err++; $display("FAIL random_sb: got %h required %h", a, e); end
        end
    endtask

    initial begin
        RESET = 1'b1; CLK_EN_IN = 1'b0; HOLD = 1'b0; RESYNC = 1'b0;
        @(posedge CLK);
        model_step(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        test_reset;
        test_startup;
        test_hold;
        test_resync;
        test_reset_in_align;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
